// File: rtl/mini_cpu_pkg.sv
// Shared types and constants for the mini CPU front end.
package mini_cpu_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      FLUSH
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_KEEP,
      PC_INC,
      PC_TGT
   } pc_sel_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Fetch address register with next-PC selection.
// Targets are forced word aligned on load.
module pc_reg
   import mini_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  pc_sel_t     sel_i,
   input  logic [31:0] target_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      case (sel_i)
         PC_INC:  pc_d = pc_q + 32'(INSTR_BYTES);
         PC_TGT:  pc_d = target_i & ~32'd3;
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request,
// a single-entry output holding register and a handoff counter.
module instr_fetch
   import mini_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] fetch_count
);

   fetch_state_t state_q, state_d;
   pc_sel_t      pc_sel;
   logic         latch;
   logic         cnt_inc;
   logic [31:0]  fetch_pc;
   logic [31:0]  req_addr_q;
   logic [31:0]  instr_q;
   logic [31:0]  pc_q;
   logic [31:0]  cnt_q;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i    (clk),
      .rst_i    (rst),
      .sel_i    (pc_sel),
      .target_i (branch_target),
      .pc_o     (fetch_pc)
   );

   // Redirects win over ready and ack in every state.
   always_comb begin
      state_d = state_q;
      pc_sel  = PC_KEEP;
      latch   = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (branch_taken) pc_sel = PC_TGT;
         end
         FETCH: begin
            if (branch_taken) begin
               pc_sel  = PC_TGT;
               state_d = imem_ack ? FETCH : FLUSH;
            end else if (imem_ack) begin
               latch   = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_sel  = PC_TGT;
               state_d = FETCH;
            end else if (instr_ready) begin
               pc_sel  = PC_INC;
               cnt_inc = 1'b1;
               state_d = FETCH;
            end
         end
         FLUSH: begin
            if (branch_taken) pc_sel = PC_TGT;
            if (imem_ack) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_addr_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_q       <= RESET_PC;
         cnt_q      <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FETCH) req_addr_q <= fetch_pc;
         if (latch) begin
            instr_q <= imem_rdata;
            pc_q    <= fetch_pc;
         end
         if (cnt_inc) cnt_q <= cnt_q + 32'd1;
      end
   end

   // FLUSH keeps presenting the abandoned address until its ack.
   assign imem_req    = (state_q == FETCH) || (state_q == FLUSH);
   assign imem_addr   = (state_q == FLUSH) ? req_addr_q : fetch_pc;
   assign instr_valid = (state_q == HOLD);
   assign instr       = instr_valid ? instr_q : NOP_INSTR;
   assign pc          = pc_q;
   assign fetch_count = cnt_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req  output  1  instruction memory request.
REQ-005 imem_addr  output  32  fetch address, word aligned.
REQ-006 imem_ack  input  1  memory response valid; may assert in the same cycle as imem_req.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 instr  output  32  instruction to the control/decode stage.
REQ-009 pc  output  32  address of the presented instr.
REQ-010 instr_valid  output  1  instr/pc valid.
REQ-011 instr_ready  input  1  downstream accepts instr this cycle.
REQ-012 branch_taken  input  1  redirect request from execute stage.
REQ-013 branch_target  input  32  redirect address; bits [1:0] forced to 0.
REQ-014 fetch_count  output  32  number of completed handoffs (instr_valid & instr_ready).

Function
REQ-015 The FSM shall have the states IDLE, FETCH, HOLD and FLUSH.
REQ-016 IDLE: imem_req=0; the FSM shall go to FETCH at the next cycle.
REQ-017 FETCH: imem_req=1 and imem_addr=fetch_pc; on imem_ack, rdata shall be latched into instr, fetch_pc into pc, and the FSM shall go to HOLD (instr_valid=1 the next cycle, giving ack-to-valid latency of 1).
REQ-018 While imem_req=1 and imem_ack=0, imem_addr shall be held stable; at most one request shall be outstanding.
REQ-019 HOLD: instr_valid=1 and instr/pc shall be held stable until instr_ready=1; on handoff, fetch_pc shall become pc+4, the FSM shall go to FETCH, and fetch_count shall increment.
REQ-020 HOLD with instr_ready=0 shall persist indefinitely, with imem_req=0.
REQ-021 branch_taken shall have priority over instr_ready and imem_ack in every state.
REQ-022 branch_taken in HOLD: instr_valid shall drop the next cycle, there shall be no handoff and no count, fetch_pc shall become the target, and the FSM shall go to FETCH.
REQ-023 branch_taken in FETCH with imem_ack=1: the response shall be discarded, fetch_pc shall become the target, and the FSM shall stay in FETCH (new request next cycle).
REQ-024 branch_taken in FETCH with imem_ack=0: fetch_pc shall become the target and the FSM shall go to FLUSH; FLUSH shall keep imem_req=1 with the old address until imem_ack, discard the data, then go to FETCH.
REQ-025 branch_taken in FLUSH shall overwrite the stored target; the latest target wins.
REQ-026 branch_taken in IDLE shall replace RESET_PC as the first fetch address.
REQ-027 pc+4 and fetch_count shall wrap modulo 2^32.
REQ-028 When instr_valid=0, instr shall read NOP (32'h0000_0013) and pc shall hold its last value.

Reset
REQ-029 rst=1 shall force state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instr=NOP, instr_valid=0, imem_req=0, imem_addr=RESET_PC and fetch_count=0 at the next edge.
REQ-030 Reset mid-transaction shall abandon any outstanding request; a late imem_ack arriving while in IDLE shall be ignored.

Structure
REQ-031 Package mini_cpu_pkg shall hold the fetch_state_t enum, INSTR_BYTES=4 and NOP_INSTR=32'h0000_0013.
REQ-032 The fetch_pc register with its next-PC selection (reset / +4 / target) shall be a sub-module pc_reg; the FSM, output registers and counter shall stay in instr_fetch.

Verification
REQ-033 Zero-wait memory (ack same cycle as req), ready tied 1 -> pc sequence 0x0, 0x4, 0x8 on successive handoffs, fetch_count=3 after three handoffs.
REQ-034 Ready held 0 for 5 cycles with instr=0x02208463 at pc=0x0 -> instr, pc and valid stable for all 5 cycles, no imem_req, and fetch_count unchanged.
REQ-035 branch_taken with target 0x40 during HOLD at pc=0x8 -> valid drops, next imem_addr=0x40, and no count increment.
REQ-036 branch_taken with target 0x100 while a request to 0xC is waiting (ack after 3 cycles) -> imem_addr stays 0xC until ack, data is discarded, next request is 0x100, and the first valid pc is 0x100.
REQ-037 Target 0x103 -> imem_addr=0x100.
REQ-038 rst asserted during FETCH with an outstanding request -> all outputs take their reset values; a late ack causes no instr_valid; fetch resumes at RESET_PC.
